// File: rtl/intr_controller.sv
// Push-button interrupt controller: synchronize, debounce, latch presses as sticky
// pending flags, and hand one masked, fixed-priority request at a time to the CPU.
module intr_controller #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic [3:0] intr_mask,
  input  logic       intr_ack,
  output logic [7:0] intr,
  output logic [3:0] pending,
  output logic       busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    ACK_WAIT = 2'd2
  } state_t;

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       deb;
  logic [3:0]       deb_d;
  logic [3:0]       armed;
  logic [CNT_W-1:0] cnt [4];
  logic [1:0]       settle;
  logic             settled;
  logic [3:0]       press;
  logic [3:0]       cand;
  logic [3:0]       clr;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic [7:0]       intr_next;
  state_t           state;
  state_t           state_next;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizer, idle level is released (1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= buttons;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level only follows after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      deb <= '1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A source only arms once it has been seen released after the synchronizer has
  // flushed its reset value, so a button held through reset cannot fake a press.
  assign settled = (settle == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle <= '0;
      armed  <= '0;
      deb_d  <= '1;
    end else begin
      if (!settled) settle <= settle + 2'd1;
      armed <= armed | ({4{settled}} & deb & sync_p1);
      deb_d <= deb;
    end
  end

  assign press = deb_d & ~deb & armed;

  // Set takes priority over the acknowledge clear so a coincident press survives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~clr) | press;
  end

  assign cand = pending & intr_mask;

  always_comb begin
    state_next = state;
    intr_next  = intr;
    idx_next   = idx;
    clr        = '0;
    case (state)
      IDLE: begin
        intr_next = '0;
        if (cand != '0) begin
          idx_next   = lowest_set(cand);
          intr_next  = 8'h01 << lowest_set(cand);
          state_next = REQ;
        end
      end
      REQ: begin
        if (intr_ack) begin
          clr        = 4'b0001 << idx;
          intr_next  = '0;
          state_next = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        intr_next = '0;
        if (!intr_ack) state_next = IDLE;
      end
      default: begin
        intr_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      intr  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      intr  <= intr_next;
      idx   <= idx_next;
      busy  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller with DEBOUNCE_CYCLES = 4; inputs change 1 time
// unit after a rising edge and outputs are sampled at that same point.
module tb_intr_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic [3:0] intr_mask;
  logic       intr_ack;
  logic [7:0] intr;
  logic [3:0] pending;
  logic       busy;

  int checks = 0;
  int errors = 0;

  intr_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .intr_mask (intr_mask),
    .intr_ack  (intr_ack),
    .intr      (intr),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; buttons = 4'b0000; intr_mask = 4'b1111; intr_ack = 1'b0;
    tick(3);
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL reset_intr got %h want 00", intr); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b want 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1;
    tick(20);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL held_through_reset pending got %b want 0000", pending); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL held_through_reset intr got %h want 00", intr); end
    buttons = 4'b1111;
    tick(12);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL release_after_reset pending got %b want 0000", pending); end
  endtask

  task automatic test_single_press;
    buttons = 4'b1101;
    tick(6);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_pending_early got %b want 0000", pending); end
    tick(1);
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL single_pending got %b want 0010", pending); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL single_intr_early got %h want 00", intr); end
    tick(1);
    checks++; if (intr !== 8'h02) begin errors++; $display("FAIL single_intr got %h want 02", intr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    intr_ack = 1'b1;
    tick(1);
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL single_ack_intr got %h want 00", intr); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_ack_pending got %b want 0000", pending); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_ackwait_busy got %b want 1", busy); end
    intr_ack = 1'b0;
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
    buttons = 4'b1111;
    tick(10);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_release pending got %b want 0000", pending); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL single_release intr got %h want 00", intr); end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 20; i++) begin
      buttons = {3'b111, ((i / 2) % 2 == 1)};
      tick(1);
    end
    buttons = 4'b1111;
    tick(10);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL bounce_pending got %b want 0000", pending); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL bounce_intr got %h want 00", intr); end
  endtask

  task automatic test_priority;
    buttons = 4'b0101;
    tick(8);
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got %b want 1010", pending); end
    checks++; if (intr !== 8'h02) begin errors++; $display("FAIL prio_first got %h want 02", intr); end
    buttons = 4'b0100;
    tick(8);
    checks++; if (pending !== 4'b1011) begin errors++; $display("FAIL prio_new_pending got %b want 1011", pending); end
    checks++; if (intr !== 8'h02) begin errors++; $display("FAIL prio_hold got %h want 02", intr); end
    intr_ack = 1'b1;
    tick(1);
    checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL prio_clear1 got %b want 1001", pending); end
    intr_ack = 1'b0;
    tick(2);
    checks++; if (intr !== 8'h01) begin errors++; $display("FAIL prio_second got %h want 01", intr); end
    intr_ack = 1'b1;
    tick(1);
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_clear0 got %b want 1000", pending); end
    intr_ack = 1'b0;
    tick(2);
    checks++; if (intr !== 8'h08) begin errors++; $display("FAIL prio_third got %h want 08", intr); end
    intr_ack = 1'b1;
    tick(1);
    intr_ack = 1'b0;
    tick(1);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_drained got %b want 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle_busy got %b want 0", busy); end
    buttons = 4'b1111;
    tick(10);
  endtask

  task automatic test_mask;
    intr_mask = 4'b1011;
    buttons = 4'b1011;
    tick(10);
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL mask_pending got %b want 0100", pending); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL mask_intr got %h want 00", intr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mask_busy got %b want 0", busy); end
    intr_mask = 4'b1111;
    tick(2);
    checks++; if (intr !== 8'h04) begin errors++; $display("FAIL unmask_intr got %h want 04", intr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unmask_busy got %b want 1", busy); end
    intr_ack = 1'b1;
    tick(1);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL unmask_ack_pending got %b want 0000", pending); end
    intr_ack = 1'b0;
    tick(1);
    buttons = 4'b1111;
    tick(10);
  endtask

  task automatic test_collision;
    buttons = 4'b1110;
    tick(8);
    checks++; if (intr !== 8'h01) begin errors++; $display("FAIL coll_first got %h want 01", intr); end
    buttons = 4'b1111;
    tick(8);
    checks++; if (intr !== 8'h01) begin errors++; $display("FAIL coll_hold got %h want 01", intr); end
    buttons = 4'b1110;
    tick(6);
    intr_ack = 1'b1;
    tick(1);
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL coll_set_wins got %b want 0001", pending); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL coll_ack_intr got %h want 00", intr); end
    intr_ack = 1'b0;
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coll_idle_busy got %b want 0", busy); end
    tick(1);
    checks++; if (intr !== 8'h01) begin errors++; $display("FAIL coll_reassert got %h want 01", intr); end
    intr_ack = 1'b1;
    tick(1);
    intr_ack = 1'b0;
    tick(1);
    buttons = 4'b1111;
    tick(10);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL coll_drained got %b want 0000", pending); end
  endtask

  task automatic test_reset_mid;
    buttons = 4'b0111;
    tick(8);
    checks++; if (intr !== 8'h08) begin errors++; $display("FAIL mid_req got %h want 08", intr); end
    #2 reset = 1'b0;
    #1;
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL mid_async_intr got %h want 00", intr); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mid_async_pending got %b want 0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %b want 0", busy); end
    tick(1);
    reset = 1'b1;
    tick(15);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mid_held pending got %b want 0000", pending); end
    buttons = 4'b1111;
    tick(10);
    buttons = 4'b0111;
    tick(7);
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL mid_rearm got %b want 1000", pending); end
    tick(1);
    intr_ack = 1'b1;
    tick(1);
    intr_ack = 1'b0;
    tick(1);
    buttons = 4'b1111;
    tick(10);
  endtask

  task automatic test_ack_idle;
    intr_ack = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ack_idle_busy got %b want 0", busy); end
    checks++; if (intr !== 8'h00) begin errors++; $display("FAIL ack_idle_intr got %h want 00", intr); end
    intr_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b0; buttons = 4'b1111; intr_mask = 4'b1111; intr_ack = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_single_press;
    test_bounce;
    test_priority;
    test_mask;
    test_collision;
    test_reset_mid;
    test_ack_idle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/intr_controller.md
# intr_controller

Button interrupt controller between the board push-buttons and the CPU interrupt input in the data-logger top level. It synchronizes and debounces the four active-low buttons and latches each press as a sticky pending flag. It applies a per-source mask and presents one interrupt at a time to the CPU as a one-hot 8-bit vector. It holds that vector until the CPU acknowledges, so no press is lost and no vector bit is self-latched.

## Interface

- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a button's debounced level changes; legal range 2..65535.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- buttons  in  4  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
- intr_mask  in  4  per-source enable; 1 = source may be requested.
- intr_ack  in  1  CPU acknowledge, level; high = current request accepted.
- intr  out  8  one-hot request to CPU; bit i = button i; bits 7:4 always 0.
- pending  out  4  sticky pending flags, one per button.
- busy  out  1  high while a request is outstanding (states REQ or ACK_WAIT).

## Operation

- Reset (reset = 0, asynchronous):
  - intr = 0, pending = 0, busy = 0, state = IDLE.
  - Synchronizer flops = 1, debounced levels = 1 (released), debounce counters = 0.
- Synchronizer: 2-flop chain per button.
- Debounce, per button:
  - Counter increments while the synchronized level ≠ debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES − 1 and the levels still differ, the debounced level takes the synchronized value and the counter clears.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES)); no wrap is possible.
- Press event: debounced level 1→0 sets pending[i]. Release events have no effect.
- Repeated presses of a source already pending merge into one pending bit.
- Masked sources still set pending; they are only excluded from arbitration.
- Arbitration: fixed priority, button 0 highest. The candidate set is pending & intr_mask.
- FSM:
  - IDLE: if candidates ≠ 0, latch idx = lowest set candidate, drive intr = 1<<idx, go to REQ. Otherwise stay.
  - REQ: hold intr. A change to intr_mask or a new pending bit does not retract or change the request. On intr_ack = 1: clear pending[idx], drive intr = 0, go to ACK_WAIT.
  - ACK_WAIT: intr = 0. On intr_ack = 0 go to IDLE.
- Simultaneous set and clear of the same pending bit in one cycle: set wins (the new press is kept).
- intr_ack high while in IDLE is ignored.
- Reset asserted mid-request: everything returns to reset values immediately. A button held through reset release does not generate a press; its debounced level must first see a release.

## Timing

- All outputs are registered. intr, pending and busy change only on clk rising edges, except on asynchronous reset.
- Press latency: let edge 0 be the first rising edge at which the raw button is sampled low, with the input stable thereafter.
  - pending[i] = 1 after edge DEBOUNCE_CYCLES + 2.
  - intr[i] = 1 and busy = 1 after edge DEBOUNCE_CYCLES + 3, if the source is unmasked and the FSM was in IDLE.
- Acknowledge:
  - intr_ack sampled high at edge n gives intr = 0 and pending[idx] = 0 after edge n.
  - intr_ack sampled low at edge m > n returns the FSM to IDLE after edge m; busy = 0 from then on.
  - The next request can appear after edge m + 1.
- Bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no event.
- Throughput: at most one acknowledged interrupt per 3 cycles.

## Test plan

DEBOUNCE_CYCLES = 4 for all scenarios; intr_mask = 4'b1111 unless stated.

- Reset check: hold reset = 0 with buttons = 4'b0000 → intr = 0, pending = 0, busy = 0. Release reset with the buttons still held → no pending bit sets until the buttons are released and pressed again.
- Single press: buttons = 4'b1101 held from edge 0 → pending = 4'b0010 after edge 6, intr = 8'h02 after edge 7. intr_ack pulsed high → intr = 0, pending = 0. intr_ack low → busy = 0.
- Bounce rejection: button 0 toggles low/high every 2 cycles for 20 cycles, then stays high → pending stays 0 and intr stays 0.
- Priority and hold: buttons 3 and 1 pressed on the same cycle → intr = 8'h02 first. Pressing button 0 during REQ leaves intr = 8'h02. After the ack handshake intr = 8'h01, then 8'h08 last.
- Masking: intr_mask = 4'b1011, press button 2 → pending = 4'b0100 and intr = 0. Set intr_mask = 4'b1111 → intr = 8'h04 two edges later.
- Set/clear collision: while intr = 8'h01, a new debounced press of button 0 lands on the same edge as intr_ack → pending[0] stays 1, and intr = 8'h01 is re-asserted after the ACK_WAIT → IDLE sequence.
